// File: rtl/ps2_kbd_pkg.sv
// Shared definitions for the PS/2 keyboard port: register map, STATUS bit
// positions, receiver state encoding and the received-frame bundle.
package ps2_kbd_pkg;

    localparam logic [2:0] REG_DATA   = 3'd0;
    localparam logic [2:0] REG_STATUS = 3'd1;
    localparam logic [2:0] REG_COUNT  = 3'd2;
    localparam logic [2:0] REG_CTRL   = 3'd3;

    localparam int ST_NOT_EMPTY  = 0;
    localparam int ST_FULL       = 1;
    localparam int ST_OVERFLOW   = 2;
    localparam int ST_PARITY_ERR = 3;
    localparam int ST_FRAME_ERR  = 4;
    localparam int ST_IRQ_EN     = 7;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_e;

    typedef struct packed {
        logic       valid;
        logic       timeout;
        logic [7:0] data;
        logic       parity_ok;
        logic       stop_ok;
    } rx_frame_t;

endpackage

// File: rtl/ps2_keyboard_port_if.sv
// 68000 IO-bus connection of the keyboard port: select, strobes, register
// index, write data and the active-low interrupt request.
interface ps2_keyboard_port_if;

    logic       Kbd_Select_H;
    logic       AS_L;
    logic       UDS_L;
    logic       WE_L;
    logic [2:0] Address;
    logic [7:0] DataIn;
    logic       Kbd_IRQ_L;

    modport master (
        output Kbd_Select_H, AS_L, UDS_L, WE_L, Address, DataIn,
        input  Kbd_IRQ_L
    );

    modport slave (
        input  Kbd_Select_H, AS_L, UDS_L, WE_L, Address, DataIn,
        output Kbd_IRQ_L
    );

endinterface

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: synchronises and de-glitches the pins, then walks
// start/data/parity/stop on filtered falling edges with an inactivity timeout.
module ps2_rx_frame
    import ps2_kbd_pkg::*;
#(
    parameter int FILTER_CYCLES  = 8,
    parameter int TIMEOUT_CYCLES = 25000
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      ps2_clk,
    input  logic      ps2_dat,
    output rx_frame_t rx
);

    localparam int FW = $clog2(FILTER_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]    clk_sync_q, clk_sync_d;
    logic [1:0]    dat_sync_q, dat_sync_d;
    logic          filt_q, filt_d;
    logic [FW-1:0] filt_cnt_q, filt_cnt_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    rx_state_e     state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic          fall, dat_bit, tmo_hit;

    // Synchroniser, glitch filter and timeout counter
    always_comb begin
        clk_sync_d = {clk_sync_q[0], ps2_clk};
        dat_sync_d = {dat_sync_q[0], ps2_dat};
        filt_d     = filt_q;
        filt_cnt_d = '0;
        if (clk_sync_q[1] != filt_q) begin
            if (filt_cnt_q == FW'(FILTER_CYCLES - 1)) filt_d = clk_sync_q[1];
            else                                      filt_cnt_d = filt_cnt_q + 1'b1;
        end
        fall    = filt_q & ~filt_d;
        dat_bit = dat_sync_q[1];
        tmo_hit = (state_q != RX_IDLE) && !fall && (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));
        tmo_cnt_d = (fall || state_q == RX_IDLE || tmo_hit) ? '0 : tmo_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            filt_q     <= 1'b1;
            filt_cnt_q <= '0;
            tmo_cnt_q  <= '0;
            bit_cnt_q  <= '0;
        end else begin
            clk_sync_q <= clk_sync_d;
            dat_sync_q <= dat_sync_d;
            filt_q     <= filt_d;
            filt_cnt_q <= filt_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        shift_q <= shift_d;
        par_q   <= par_d;
    end

    // Frame FSM: state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= RX_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (fall) begin
            case (state_q)
                RX_IDLE:   if (!dat_bit) state_d = RX_DATA;
                RX_DATA:   if (bit_cnt_q == 3'd7) state_d = RX_PARITY;
                RX_PARITY: state_d = RX_STOP;
                RX_STOP:   state_d = RX_IDLE;
                default:   state_d = RX_IDLE;
            endcase
        end else if (tmo_hit) begin
            state_d = RX_IDLE;
        end
    end

    // Shift register collects data LSB first; the first bit lands in [0]
    always_comb begin
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        if (fall) begin
            case (state_q)
                RX_IDLE:   bit_cnt_d = '0;
                RX_DATA: begin
                    shift_d   = {dat_bit, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                end
                RX_PARITY: par_d = dat_bit;
                default: ;
            endcase
        end
    end

    always_comb begin
        rx           = '0;
        rx.valid     = fall && (state_q == RX_STOP);
        rx.timeout   = tmo_hit;
        rx.data      = shift_q;
        rx.parity_ok = ^{par_q, shift_q};
        rx.stop_ok   = dat_bit;
    end

endmodule

// File: rtl/ps2_keyboard_port.sv
// 68000-bus PS/2 keyboard port: buffers received scan codes in a FIFO and
// exposes DATA/STATUS/COUNT/CTRL registers with a level interrupt.
module ps2_keyboard_port
    import ps2_kbd_pkg::*;
#(
    parameter int FIFO_DEPTH     = 16,
    parameter int FILTER_CYCLES  = 8,
    parameter int TIMEOUT_CYCLES = 25000
) (
    input  logic                Clk,
    input  logic                Reset_H,
    ps2_keyboard_port_if.slave  bus,
    // Kept as a plain port so the tri-state driver sits at the block boundary
    output logic [7:0]          DataOut,
    input  logic                ps2_clk,
    input  logic                ps2_dat
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    rx_frame_t     rx;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d, perr_q, perr_d, ferr_q, ferr_d;
    logic          irq_en_q, irq_en_d, irq_l_q, irq_l_d;
    logic          acc_q, acc_d;
    logic          acc_rise, rd_strobe, wr_strobe, stat_wr;
    logic          empty, full, pop, push, flush, good;
    logic          set_ovf, set_perr, set_ferr;
    logic [7:0]    rd_data;

    ps2_rx_frame #(
        .FILTER_CYCLES  (FILTER_CYCLES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rx (
        .clk     (Clk),
        .rst     (Reset_H),
        .ps2_clk (ps2_clk),
        .ps2_dat (ps2_dat),
        .rx      (rx)
    );

    // Bus decode; acc_q tracks the access term through reset so a cycle held
    // across reset release does not look like a fresh access
    always_comb begin
        acc_d     = bus.Kbd_Select_H & ~bus.AS_L & ~bus.UDS_L;
        acc_rise  = acc_d & ~acc_q;
        rd_strobe = acc_rise & bus.WE_L;
        wr_strobe = acc_rise & ~bus.WE_L;
        empty     = (count_q == '0);
        full      = (count_q == CW'(FIFO_DEPTH));
        pop       = rd_strobe && (bus.Address == REG_DATA) && !empty;
        flush     = wr_strobe && (bus.Address == REG_CTRL) && bus.DataIn[0];
        stat_wr   = wr_strobe && (bus.Address == REG_STATUS);
        good      = rx.valid & rx.stop_ok & rx.parity_ok;
        push      = good & (~full | pop);
        set_ovf   = good & full & ~pop;
        set_perr  = rx.valid & rx.stop_ok & ~rx.parity_ok;
        set_ferr  = (rx.valid & ~rx.stop_ok) | rx.timeout;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: ;
            endcase
        end
    end

    // Sticky flags: a new event in the same cycle as its W1C keeps the flag set
    always_comb begin
        ovf_d    = (ovf_q  & ~(stat_wr & bus.DataIn[ST_OVERFLOW]))   | set_ovf;
        perr_d   = (perr_q & ~(stat_wr & bus.DataIn[ST_PARITY_ERR])) | set_perr;
        ferr_d   = (ferr_q & ~(stat_wr & bus.DataIn[ST_FRAME_ERR]))  | set_ferr;
        irq_en_d = irq_en_q | (stat_wr & bus.DataIn[ST_IRQ_EN]);
        irq_l_d  = ~(irq_en_q & (~empty | ovf_q));
    end

    always_ff @(posedge Clk) begin
        if (Reset_H) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
            irq_en_q <= 1'b0;
            irq_l_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            perr_q   <= perr_d;
            ferr_q   <= ferr_d;
            irq_en_q <= irq_en_d;
            irq_l_q  <= irq_l_d;
        end
    end

    always_ff @(posedge Clk) begin
        acc_q <= acc_d;
        if (push && !flush && !Reset_H) mem_q[wr_ptr_q] <= rx.data;
    end

    always_comb begin
        rd_data = 8'h00;
        case (bus.Address)
            REG_DATA:   if (!empty) rd_data = mem_q[rd_ptr_q];
            REG_STATUS: rd_data = {irq_en_q, 2'b00, ferr_q, perr_q, ovf_q, full, ~empty};
            REG_COUNT:  rd_data = 8'(count_q);
            default:    rd_data = 8'h00;
        endcase
    end

    assign DataOut       = (acc_d & bus.WE_L & ~Reset_H) ? rd_data : 8'hzz;
    assign bus.Kbd_IRQ_L = irq_l_q;

endmodule
